// File: rtl/uart_host_cmd_master.sv
// uart_host_cmd_master: host-side initiator for the UART command protocol.
// Takes one command at a time, streams its byte frame to the UART TX and
// assembles the (0, 1 or 2 byte, LSB first) reply into a 16-bit response.
// Optional response timeout: define HOST_TIMEOUT_EN.
module uart_host_cmd_master #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [1:0]            CMD_TYPE,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [DATA_WIDTH-1:0] CMD_WDATA,
  input  logic [DATA_WIDTH-1:0] CMD_OP_A,
  input  logic [DATA_WIDTH-1:0] CMD_OP_B,
  input  logic [FUN_WIDTH-1:0]  CMD_FUN,
  output logic [7:0]            TX_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  input  logic [7:0]            RX_DATA,
  input  logic                  RX_VALID,
  output logic [15:0]           RSP_DATA,
  output logic                  RSP_VALID,
  output logic                  RSP_TIMEOUT,
  output logic                  BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_RSP, S_DONE} state_t;

  state_t                state_q;
  logic [1:0]            typ_q;
  logic [1:0]            idx_q;      // index of the byte currently on TX_DATA
  logic                  rx_cnt_q;   // response bytes already captured
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, opa_q, opb_q;
  logic [FUN_WIDTH-1:0]  fun_q;
  logic                  cmd_ready_q, tx_valid_q, rsp_valid_q, busy_q;
  logic [7:0]            tx_data_q;
  logic [15:0]           rsp_data_q;
`ifdef HOST_TIMEOUT_EN
  logic                  rsp_timeout_q;
  logic [31:0]           tmo_q;
`endif

  logic [1:0] last_idx_d, rsp_need_d, idx_d;
  logic [7:0] nxt_byte_d;

  function automatic logic [7:0] header(input logic [1:0] t);
    case (t)
      2'd0:    return 8'hAA;
      2'd1:    return 8'hBB;
      2'd2:    return 8'hCC;
      default: return 8'hDD;
    endcase
  endfunction

  // Frame geometry per command type and the byte that follows the current one.
  always_comb begin
    idx_d      = idx_q + 2'd1;
    last_idx_d = 2'd1;
    rsp_need_d = 2'd2;
    nxt_byte_d = 8'h00;
    case (typ_q)
      2'd0: begin
        last_idx_d = 2'd2;
        rsp_need_d = 2'd0;
        nxt_byte_d = (idx_d == 2'd1) ? 8'(addr_q) : 8'(wdata_q);
      end
      2'd1: begin
        rsp_need_d = 2'd1;
        nxt_byte_d = 8'(addr_q);
      end
      2'd2: begin
        last_idx_d = 2'd3;
        nxt_byte_d = (idx_d == 2'd1) ? 8'(opa_q) :
                     (idx_d == 2'd2) ? 8'(opb_q) : 8'(fun_q);
      end
      default: nxt_byte_d = 8'(fun_q);
    endcase
  end

  // Command FSM: accept, stream frame, collect reply, one-cycle DONE strobe.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      typ_q       <= 2'd0;
      idx_q       <= 2'd0;
      rx_cnt_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      fun_q       <= '0;
      cmd_ready_q <= 1'b1;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
      busy_q      <= 1'b0;
`ifdef HOST_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
      tmo_q         <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
`ifdef HOST_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: if (CMD_VALID) begin
          typ_q       <= CMD_TYPE;
          addr_q      <= CMD_ADDR;
          wdata_q     <= CMD_WDATA;
          opa_q       <= CMD_OP_A;
          opb_q       <= CMD_OP_B;
          fun_q       <= CMD_FUN;
          idx_q       <= 2'd0;
          rx_cnt_q    <= 1'b0;
          tx_data_q   <= header(CMD_TYPE);
          tx_valid_q  <= 1'b1;
          cmd_ready_q <= 1'b0;
          busy_q      <= 1'b1;
          state_q     <= S_SEND;
        end
        S_SEND: if (TX_READY) begin
          if (idx_q == last_idx_d) begin
            tx_valid_q <= 1'b0;
            if (rsp_need_d == 2'd0) begin
              // Writes still report completion, with an all-zero word.
              rsp_data_q  <= 16'h0000;
              rsp_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              state_q <= S_WAIT_RSP;
`ifdef HOST_TIMEOUT_EN
              tmo_q <= '0;
`endif
            end
          end else begin
            idx_q     <= idx_d;
            tx_data_q <= nxt_byte_d;
          end
        end
        S_WAIT_RSP: begin
          if (RX_VALID) begin
            // First byte also clears the high half so a 1-byte reply reads 0x00XX.
            if (!rx_cnt_q) rsp_data_q <= {8'h00, RX_DATA};
            else           rsp_data_q[15:8] <= RX_DATA;
            rx_cnt_q <= 1'b1;
            if (rsp_need_d == ({1'b0, rx_cnt_q} + 2'd1)) begin
              rsp_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
`ifdef HOST_TIMEOUT_EN
            tmo_q <= '0;
          end else if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
            rsp_timeout_q <= 1'b1;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + 32'd1;
`endif
          end
        end
        S_DONE: begin
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign CMD_READY = cmd_ready_q;
  assign TX_DATA   = tx_data_q;
  assign TX_VALID  = tx_valid_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_VALID = rsp_valid_q;
  assign BUSY      = busy_q;
`ifdef HOST_TIMEOUT_EN
  assign RSP_TIMEOUT = rsp_timeout_q;
`else
  assign RSP_TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_uart_host_cmd_master.sv
// Bench for uart_host_cmd_master: directed test-plan scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// queue-based frame/response model.
module tb_uart_host_cmd_master;
  localparam int TMO = 16;

  logic       CLK = 1'b0, RST = 1'b1;
  logic       CMD_VALID = 1'b0, CMD_READY;
  logic [1:0] CMD_TYPE = '0;
  logic [3:0] CMD_ADDR = '0, CMD_FUN = '0;
  logic [7:0] CMD_WDATA = '0, CMD_OP_A = '0, CMD_OP_B = '0;
  logic [7:0] TX_DATA, RX_DATA;
  logic       TX_VALID, TX_READY, RX_VALID;
  logic [15:0] RSP_DATA;
  logic       RSP_VALID, RSP_TIMEOUT, BUSY;

  // stimulus sources for the shared inputs
  logic rnd_en = 1'b0, tgl_en = 1'b0, dir_txr = 1'b1, dir_rxv = 1'b0;
  logic [7:0] dir_rxd = '0;
  logic rnd_txr = 1'b1, rnd_rxv = 1'b0, tgl_txr = 1'b1;
  logic [7:0] rnd_rxd = '0;
  assign TX_READY = rnd_en ? rnd_txr : (tgl_en ? tgl_txr : dir_txr);
  assign RX_VALID = rnd_en ? rnd_rxv : dir_rxv;
  assign RX_DATA  = rnd_en ? rnd_rxd : dir_rxd;

  uart_host_cmd_master #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4),
                         .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_TYPE(CMD_TYPE), .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .CMD_OP_A(CMD_OP_A), .CMD_OP_B(CMD_OP_B), .CMD_FUN(CMD_FUN),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RSP_DATA(RSP_DATA),
    .RSP_VALID(RSP_VALID), .RSP_TIMEOUT(RSP_TIMEOUT), .BUSY(BUSY));

  always #5 CLK = ~CLK;

  // random/toggling input drivers, changed mid-cycle
  always @(negedge CLK) begin
    rnd_txr = ($urandom % 10) < 7;
    rnd_rxv = ($urandom % 10) < 3;
    rnd_rxd = 8'($urandom);
    tgl_txr = ~tgl_txr;
  end

  // ---------------- behavioural model ----------------
  logic m_ready, m_busy, m_txv, m_rspv, m_tmo;
  logic [7:0] m_txd;
  logic [15:0] m_rsp;
  logic [7:0] m_q[$];
  int m_need, m_got, m_cnt;
  bit m_wait, m_done;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_ready = 1; m_busy = 0; m_txv = 0; m_txd = 0; m_rspv = 0; m_tmo = 0;
      m_rsp = 0; m_q.delete(); m_wait = 0; m_done = 0;
      m_need = 0; m_got = 0; m_cnt = 0;
    end else begin
      m_rspv = 0; m_tmo = 0;
      if (m_done) begin
        m_done = 0; m_ready = 1; m_busy = 0;
      end else if (m_ready) begin
        if (CMD_VALID) begin
          case (CMD_TYPE)
            2'd0: begin m_q = '{8'hAA, 8'(CMD_ADDR), CMD_WDATA}; m_need = 0; end
            2'd1: begin m_q = '{8'hBB, 8'(CMD_ADDR)}; m_need = 1; end
            2'd2: begin m_q = '{8'hCC, CMD_OP_A, CMD_OP_B, 8'(CMD_FUN)}; m_need = 2; end
            default: begin m_q = '{8'hDD, 8'(CMD_FUN)}; m_need = 2; end
          endcase
          m_ready = 0; m_busy = 1; m_txv = 1; m_txd = m_q[0];
        end
      end else if (m_q.size() != 0) begin
        if (TX_READY) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_txv = 0;
            if (m_need == 0) begin m_done = 1; m_rspv = 1; m_rsp = 0; end
            else begin m_wait = 1; m_cnt = 0; m_got = 0; end
          end else m_txd = m_q[0];
        end
      end else if (m_wait) begin
        if (RX_VALID) begin
          if (m_got == 0) m_rsp = {8'h00, RX_DATA};
          else            m_rsp[15:8] = RX_DATA;
          m_got++; m_cnt = 0;
          if (m_got == m_need) begin m_wait = 0; m_done = 1; m_rspv = 1; end
        end
`ifdef HOST_TIMEOUT_EN
        else if (m_cnt == TMO - 1) begin
          m_wait = 0; m_tmo = 1; m_ready = 1; m_busy = 0;
        end
`endif
        else m_cnt++;
      end
    end
  end

  // ---------------- monitor ----------------
  int cyc = 0, hs_cyc = 0, rx_cyc = 0;
  logic [7:0] tx_log[$];
  always @(posedge CLK) begin
    cyc++;
    if (!RST && TX_VALID && TX_READY) begin tx_log.push_back(TX_DATA); hs_cyc = cyc - 1; end
    if (!RST && RX_VALID) rx_cyc = cyc - 1;
  end

  // ---------------- checking ----------------
  int checks = 0, failures = 0;
  int rsp_cnt = 0, tmo_cnt = 0, rv_cyc = 0, tmo_cyc = 0;
  logic [15:0] last_rsp = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    chk("CMD_READY", 32'(CMD_READY), 32'(m_ready));
    chk("TX_VALID", 32'(TX_VALID), 32'(m_txv));
    if (m_txv) chk("TX_DATA", 32'(TX_DATA), 32'(m_txd));
    chk("RSP_VALID", 32'(RSP_VALID), 32'(m_rspv));
    chk("RSP_DATA", 32'(RSP_DATA), 32'(m_rsp));
    chk("RSP_TIMEOUT", 32'(RSP_TIMEOUT), 32'(m_tmo));
    chk("BUSY", 32'(BUSY), 32'(m_busy));
    if (RSP_VALID) begin rsp_cnt++; last_rsp = RSP_DATA; rv_cyc = cyc; end
    if (RSP_TIMEOUT) begin tmo_cnt++; tmo_cyc = cyc; end
  endtask

  task automatic send_cmd(input logic [1:0] t, input logic [3:0] a, input logic [7:0] w,
                          input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f);
    int n = 0;
    @(negedge CLK);
    CMD_VALID = 1; CMD_TYPE = t; CMD_ADDR = a; CMD_WDATA = w;
    CMD_OP_A = oa; CMD_OP_B = ob; CMD_FUN = f;
    while (!CMD_READY && n < 2000) begin @(negedge CLK); n++; end
    chk("cmd_accept_wait", 32'(CMD_READY), 32'd1);
    @(negedge CLK);
    // scramble fields: the DUT must work from its captured copy
    CMD_VALID = 0; CMD_TYPE = 2'($urandom); CMD_ADDR = 4'($urandom);
    CMD_WDATA = 8'($urandom); CMD_OP_A = 8'($urandom); CMD_OP_B = 8'($urandom);
    CMD_FUN = 4'($urandom);
  endtask

  task automatic wait_tx(input int n);
    int k = 0;
    while (tx_log.size() < n && k < 500) begin @(negedge CLK); k++; end
    chk("tx_byte_count_reached", 32'(tx_log.size() >= n), 32'd1);
  endtask

  task automatic wait_rsp(input int c0);
    int k = 0;
    while (rsp_cnt == c0 && k < 500) begin @(negedge CLK); k++; end
    chk("rsp_arrived", 32'(rsp_cnt != c0), 32'd1);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge CLK); dir_rxv = 1; dir_rxd = b;
    @(negedge CLK); dir_rxv = 0;
  endtask

  task automatic chk_frame(input string nm, input int base, input logic [7:0] e[$]);
    chk({nm, "_len"}, 32'(tx_log.size() - base), 32'(e.size()));
    for (int i = 0; i < e.size(); i++)
      if (base + i < tx_log.size()) chk({nm, "_byte"}, 32'(tx_log[base + i]), 32'(e[i]));
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, c0;
    fork
      forever begin @(negedge CLK); compare_cycle(); end
    join_none

    repeat (3) @(negedge CLK);
    chk("reset_CMD_READY", 32'(CMD_READY), 32'd1);
    chk("reset_TX_VALID", 32'(TX_VALID), 32'd0);
    chk("reset_TX_DATA", 32'(TX_DATA), 32'h00);
    chk("reset_RSP_DATA", 32'(RSP_DATA), 32'h0000);
    chk("reset_BUSY", 32'(BUSY), 32'd0);
    RST = 0;
    repeat (2) @(negedge CLK);

    // RF write, TX always ready
    base = tx_log.size(); c0 = rsp_cnt;
    send_cmd(2'd0, 4'h3, 8'h5A, 8'h00, 8'h00, 4'h0);
    wait_rsp(c0);
    chk_frame("wr_frame", base, '{8'hAA, 8'h03, 8'h5A});
    chk("wr_rsp", 32'(last_rsp), 32'h0000);
    chk("wr_rsp_latency", 32'(rv_cyc - hs_cyc), 32'd1);

    // RF read
    base = tx_log.size(); c0 = rsp_cnt;
    send_cmd(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0);
    wait_tx(base + 2);
    rx_byte(8'h81);
    wait_rsp(c0);
    chk_frame("rd_frame", base, '{8'hBB, 8'h02});
    chk("rd_rsp", 32'(last_rsp), 32'h0081);
    chk("rd_rsp_latency", 32'(rv_cyc - rx_cyc), 32'd1);

    // ALU with operands, TX_READY toggling
    base = tx_log.size(); c0 = rsp_cnt; tgl_en = 1;
    send_cmd(2'd2, 4'h0, 8'h00, 8'h0C, 8'h0A, 4'h2);
    wait_tx(base + 4);
    tgl_en = 0;
    rx_byte(8'h78); rx_byte(8'h00);
    wait_rsp(c0);
    chk_frame("alu_frame", base, '{8'hCC, 8'h0C, 8'h0A, 8'h02});
    chk("alu_rsp", 32'(last_rsp), 32'h0078);

    // stray RX in IDLE, then ALU without operands
    rx_byte(8'h55);
    base = tx_log.size(); c0 = rsp_cnt;
    send_cmd(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h8);
    wait_tx(base + 2);
    rx_byte(8'h01); rx_byte(8'h00);
    wait_rsp(c0);
    chk_frame("alu0_frame", base, '{8'hDD, 8'h08});
    chk("alu0_rsp", 32'(last_rsp), 32'h0001);

`ifdef HOST_TIMEOUT_EN
    // RF read with no reply
    begin
      int k = 0, t0 = tmo_cnt;
      base = tx_log.size(); c0 = rsp_cnt;
      send_cmd(2'd1, 4'h7, 8'h00, 8'h00, 8'h00, 4'h0);
      wait_tx(base + 2);
      while (tmo_cnt == t0 && k < 200) begin @(negedge CLK); k++; end
      chk("tmo_seen", 32'(tmo_cnt - t0), 32'd1);
      chk("tmo_latency", 32'(tmo_cyc - (hs_cyc + 1)), 32'(TMO));
      chk("tmo_no_rsp_valid", 32'(rsp_cnt), 32'(c0));
      @(negedge CLK);
      chk("tmo_ready_after", 32'(CMD_READY), 32'd1);
    end
`endif

    // reset after 2nd byte of an ALU frame
    base = tx_log.size();
    send_cmd(2'd2, 4'h0, 8'h00, 8'h11, 8'h22, 4'h3);
    wait_tx(base + 2);
    #2 RST = 1;
    #1;
    chk("rst_TX_VALID_now", 32'(TX_VALID), 32'd0);
    chk("rst_CMD_READY_now", 32'(CMD_READY), 32'd1);
    repeat (2) @(negedge CLK);
    RST = 0;
    repeat (10) @(negedge CLK);
    chk("rst_no_more_tx", 32'(tx_log.size() - base), 32'd2);
    chk("rst_ready_after", 32'(CMD_READY), 32'd1);
    chk("rst_busy_after", 32'(BUSY), 32'd0);

    // randomized traffic, stray RX bytes and back-to-back requests
    rnd_en = 1;
    for (int i = 0; i < 80; i++) begin
      send_cmd(2'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
               8'($urandom), 4'($urandom));
      repeat ($urandom % 3) @(negedge CLK);
    end
    begin
      int k = 0;
      while (!CMD_READY && k < 2000) begin @(negedge CLK); k++; end
      chk("final_idle", 32'(CMD_READY), 32'd1);
    end
    repeat (3) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_host_cmd_master.md
Name: uart_host_cmd_master

Overview:
- Host-side initiator for the UART command protocol decoded by the system controller.
- Accepts one command request at a time and serializes it into a byte frame on a byte-stream TX interface feeding the host UART transmitter.
- Collects the response bytes from the host UART receiver and returns a single response word.
- Used in the host/test harness and loopback integration.

Parameters:
- DATA_WIDTH, 8, byte and register data width.
- ADDR_WIDTH, 4, register-file address width, zero-extended to 8 bits on the wire.
- FUN_WIDTH, 4, ALU function width, zero-extended to 8 bits on the wire.
- TIMEOUT_CYCLES, 65535, response wait limit in CLK cycles (used only with HOST_TIMEOUT_EN).

Ports:
- CLK  in  1  block clock.
- RST  in  1  asynchronous, active-high reset.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  block idle, can accept a command.
- CMD_TYPE  in  2  command type: 0 = RF write, 1 = RF read, 2 = ALU with operands, 3 = ALU without operands.
- CMD_ADDR  in  ADDR_WIDTH  register address.
- CMD_WDATA  in  DATA_WIDTH  register write data.
- CMD_OP_A  in  DATA_WIDTH  ALU operand A.
- CMD_OP_B  in  DATA_WIDTH  ALU operand B.
- CMD_FUN  in  FUN_WIDTH  ALU function.
- TX_DATA  out  8  frame byte to UART TX.
- TX_VALID  out  1  TX_DATA valid.
- TX_READY  in  1  UART TX side accepts the byte.
- RX_DATA  in  8  byte from UART RX.
- RX_VALID  in  1  single-cycle RX byte strobe, already synchronized to CLK.
- RSP_DATA  out  16  response word.
- RSP_VALID  out  1  one-cycle response strobe.
- RSP_TIMEOUT  out  1  one-cycle timeout strobe.
- BUSY  out  1  high in any state except IDLE.

Behaviour:
- Reset values: CMD_READY = 1; TX_DATA = 0x00; TX_VALID = 0; RSP_DATA = 0x0000; RSP_VALID = 0; RSP_TIMEOUT = 0; BUSY = 0; state IDLE; all counters 0.
- Command is accepted when CMD_VALID & CMD_READY. All CMD_* fields are captured into internal registers that cycle. CMD_READY falls the next cycle.
- Frames are sent in byte order:
  - Type 0 (RF write): 0xAA, ADDR, WDATA. Expected response bytes: 0.
  - Type 1 (RF read): 0xBB, ADDR. Expected response bytes: 1.
  - Type 2 (ALU with operands): 0xCC, OP_A, OP_B, FUN. Expected response bytes: 2.
  - Type 3 (ALU without operands): 0xDD, FUN. Expected response bytes: 2.
- States: IDLE, SEND, WAIT_RSP, DONE.
  - IDLE -> SEND on accept.
  - SEND: TX_VALID is registered and high, TX_DATA holds the current byte. A byte transfers on TX_VALID & TX_READY; the byte index then increments and the next byte appears the following cycle with TX_VALID held high.
  - TX_DATA and TX_VALID stay stable while TX_READY = 0.
  - After the last byte transfers: go to DONE if 0 response bytes are expected, otherwise to WAIT_RSP.
  - WAIT_RSP: each RX_VALID stores RX_DATA. The first byte goes to RSP_DATA[7:0]; the second goes to RSP_DATA[15:8] (LSB first).
  - RF read: RSP_DATA[15:8] = 0x00.
  - When the last expected byte arrives -> DONE.
  - DONE lasts one cycle: RSP_VALID = 1 (including RF write, where RSP_DATA = 0x0000), then -> IDLE with CMD_READY = 1.
- Minimum turnaround is DONE -> IDLE -> the next accept can occur in IDLE.
- RX_VALID in IDLE, SEND, or DONE: byte is dropped, with no state change.
- RX_VALID on the same cycle as the last TX handshake: dropped (WAIT_RSP not yet entered).
- CMD_VALID while not ready: ignored. The requester must hold it.
- RSP_DATA holds its value until the next response is captured.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). A partial frame is abandoned with no further TX bytes.

Optional Feature:
- Macro: HOST_TIMEOUT_EN.
- Defined:
  - A cycle counter, cleared on entry to WAIT_RSP and on every RX_VALID in WAIT_RSP, increments each cycle in WAIT_RSP.
  - When the counter reaches TIMEOUT_CYCLES-1 without the last byte: pulse RSP_TIMEOUT for one cycle (RSP_VALID stays 0), RSP_DATA keeps the partial bytes, go to IDLE.
  - The last byte arriving on the timeout cycle wins: RSP_VALID, no timeout.
- Not defined: no counter; RSP_TIMEOUT is tied to 0; WAIT_RSP waits indefinitely, exited only by reset.

Test Plan:
- RF write addr 0x3, data 0x5A, TX_READY = 1: TX bytes 0xAA, 0x03, 0x5A on three consecutive cycles. RSP_VALID = 1 with RSP_DATA = 0x0000 one cycle after the last byte, no RX needed.
- RF read addr 0x2, RX byte 0x81: TX bytes 0xBB, 0x02. RSP_DATA = 0x0081, RSP_VALID pulse the cycle after the RX strobe.
- ALU with operands, A = 0x0C, B = 0x0A, FUN = 0x2 (multiply), TX_READY toggling 1-0-1: TX bytes 0xCC, 0x0C, 0x0A, 0x02. Bytes are held during stalls with no duplicates. RX bytes 0x78, 0x00 give RSP_DATA = 0x0078.
- Stray RX byte 0x55 in IDLE, then ALU without operands with FUN = 0x8, RX bytes 0x01, 0x00: the stray byte is ignored. TX bytes 0xDD, 0x08. RSP_DATA = 0x0001.
- HOST_TIMEOUT_EN with TIMEOUT_CYCLES = 16, RF read with no RX: RSP_TIMEOUT pulses 16 cycles after WAIT_RSP entry, RSP_VALID never asserts, CMD_READY = 1 the next cycle.
- Reset asserted after the 2nd byte of an ALU-with-operands frame: TX_VALID drops immediately, CMD_READY = 1 and BUSY = 0 after release, no further TX bytes.
